// File: rtl/scatter_if.sv
// Handshake bundle for the scatter frame deserializer: one tagged input stream
// ({index, data}) and N independent stb/rdy output channels.
interface scatter_if #(
  parameter int W = 8,
  parameter int N = 2
);
  localparam int IW = $clog2(N);

  logic              s_stb;
  logic [IW+W-1:0]   s_dat;
  logic              s_rdy;
  logic [N-1:0]      m_stb;
  logic [N*W-1:0]    m_dat;
  logic [N-1:0]      m_rdy;

  modport master (output s_stb, s_dat, m_rdy, input s_rdy, m_stb, m_dat);
  modport slave  (input s_stb, s_dat, m_rdy, output s_rdy, m_stb, m_dat);
endinterface

// File: rtl/scatter.sv
// Frame deserializer: collects one word per index into an N-slot buffer, then
// presents the whole frame on N parallel channels. Macro SCATTER_ERR_EN adds err.
module scatter #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic     clk,
  input  logic     rst,
  scatter_if.slave bus
`ifdef SCATTER_ERR_EN
  ,
  output logic     err
`endif
);
  localparam int IW = $clog2(N);

  typedef enum logic {FILL, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [N-1:0]          full_q, full_d;
  logic [N-1:0]          pend_q, pend_d;
  logic [N-1:0][W-1:0]   frame_q, frame_d;

  logic [IW-1:0] idx;
  logic [W-1:0]  wdat;
  logic          idx_ok;
  logic          accept;

  assign idx    = bus.s_dat[IW+W-1:W];
  assign wdat   = bus.s_dat[W-1:0];
  assign idx_ok = (int'(idx) < N);
  // s_rdy is high only in FILL, so an accept always belongs to the filling frame.
  assign accept = bus.s_stb & bus.s_rdy;

  assign bus.s_rdy = ~rst & (state_q == FILL);
  assign bus.m_stb = pend_q;
  assign bus.m_dat = frame_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
    state_d = state_q;
    full_d  = full_q;
    pend_d  = pend_q;
    frame_d = frame_q;
    unique case (state_q)
      FILL: begin
        if (accept && idx_ok) begin
          frame_d[idx] = wdat;
          full_d[idx]  = 1'b1;
          if (&full_d) begin
            state_d = DRAIN;
            pend_d  = '1;
            full_d  = '0;
          end
        end
      end
      DRAIN: begin
        pend_d = pend_q & ~bus.m_rdy;
        if (pend_d == '0) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: the frame buffer is reset because m_dat must read zero after reset; a plain datapath RAM would not need it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      full_q  <= '0;
      pend_q  <= '0;
      frame_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
    end
  end

`ifdef SCATTER_ERR_EN
  logic err_q, err_d;

  // Flags a duplicate slot or an out-of-range index; data handling is unaffected.
  always_comb begin
    err_d = accept & (~idx_ok | full_q[idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif
endmodule

// File: doc/scatter.md
Name: scatter

Overview:
Frame deserializer/demultiplexer for index-tagged streams of the form {index, data}, index in 0..N-1.
- Collects one word per index into an N-slot frame buffer. Words may arrive in any order.
- Once every slot is filled, presents all N words in parallel on N independent stb/rdy output channels.
- Sits on the consumer side of a tagged serial link and fans a serialized vector back out to N parallel lanes.

Parameters:
W, 8, data width per word
N, 2, number of slots/output channels; legal range N >= 2
IW (localparam), $clog2(N), index width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
s_stb  input  1  input word valid
s_dat  input  IW+W  input word; bits [IW+W-1:W] = index, bits [W-1:0] = data
s_rdy  output  1  input ready
m_stb  output  N  per-channel output valid; bit i for channel i
m_dat  output  N*W  channel i data at bits [i*W+W-1:i*W]
m_rdy  input  N  per-channel output ready

Behaviour:
- Registers:
  - state: FILL or DRAIN.
  - full[N-1:0]: slot written this frame.
  - pend[N-1:0]: slot not yet taken by its channel.
  - buf: N x W frame buffer.
- Reset (rst high at a clock edge):
  - state=FILL, full=0, pend=0, buf=0.
  - Outputs after that edge: m_stb=0, m_dat=0, s_rdy=1.
  - s_rdy is 0 in any cycle where rst is high.
  - Reset mid-frame or mid-drain discards all contents. No partial frame is ever presented.
- FILL state:
  - s_rdy=1, m_stb=0.
  - Accept when s_stb & s_rdy, with idx = s_dat index field.
  - If idx < N: buf[idx] <= data, full[idx] <= 1.
  - Duplicate idx (full[idx] already 1): buf[idx] is overwritten, full is unchanged. The latest data wins.
  - idx >= N (possible only when N is not a power of 2): word is accepted and dropped; no state change.
  - When an accept makes full all-ones: state <= DRAIN, pend <= all-ones, full <= 0.
- DRAIN state:
  - s_rdy=0; m_stb = pend; m_dat = buf, held stable.
  - Each channel is independent. Handshake m_stb[i] & m_rdy[i] clears pend[i] at that edge.
  - Any subset of channels may complete in the same cycle.
  - m_stb[i] stays high until its own handshake. It never drops while m_rdy[i] is low.
  - When pend after the clock edge is all-zero: state <= FILL.
- Latency:
  - Final filling word accepted at edge t: m_stb = all-ones in the cycle after t.
  - Last channel handshake at edge t: s_rdy=1 in the cycle after t. There is no overlap of frames, so peak throughput is one frame per N + 1 cycles with all m_rdy high.
- m_rdy is ignored in FILL. s_stb is ignored in DRAIN.
- buf is written only in FILL, so m_dat is constant throughout DRAIN.
- No combinational path from any input to any output except the register-based s_rdy/m_stb decode of state and pend. The decode must not depend on s_stb or m_rdy.

Optional Feature:
Macro SCATTER_ERR_EN.
- Defined:
  - Adds output port err (1 bit, registered, reset 0).
  - err pulses high for exactly one cycle, the cycle after an accepted word whose idx >= N or whose slot was already full.
  - Data handling is identical to the undefined case.
- Undefined:
  - No err port.
  - Duplicates are silently overwritten; out-of-range indices are silently dropped.

Test Plan:
1. W=8, N=2, all m_rdy=1: send {1,8'hAA} then {0,8'h55} on consecutive cycles -> next cycle m_stb=2'b11, m_dat=16'hAA55. One cycle later m_stb=0 and s_rdy=1.
2. N=2, m_rdy=2'b00 for 5 cycles after a full frame -> m_stb=2'b11 and m_dat stable all 5 cycles, s_rdy=0. Then raise m_rdy[0] only -> m_stb=2'b10. Then raise m_rdy[1] -> m_stb=0, s_rdy=1 on the next cycle.
3. N=2: send {0,8'h11}, {0,8'h22}, {1,8'h33} -> single frame with m_dat=16'h3322. With SCATTER_ERR_EN, err=1 for exactly one cycle, after the second word.
4. N=3, W=8: send {3,8'hFF}, {2,8'hC}, {0,8'hA}, {1,8'hB} -> the idx-3 word is dropped; m_dat=24'h0C0B0A after the fourth word. With SCATTER_ERR_EN, err pulses once, after the first word.
5. N=2: accept {0,8'h01}, then assert rst for one cycle, then send {1,8'h02} -> no m_stb. Then send {0,8'h03} -> m_dat=16'h0203.
6. N=4, random m_rdy backpressure, 100 frames with randomized index order -> every frame emitted exactly once and intact, each channel handshakes once per frame, and s_rdy=0 throughout every DRAIN.
